// File: rtl/simple_branch.sv
// -----------------------------------------------------------------------------
// simple_branch
//
// Program-counter register with a four-way next-PC selector. Each cycle the PC
// either advances by PC_INCR, loads one of three jump targets, holds (stall),
// or returns to RESET_PC (synchronous reset, which outranks stall).
//
// Ports
//   clk          in   single clock, all state changes on its rising edge
//   reset        in   synchronous active-high reset, loads RESET_PC
//   pcStall      in   1 = hold the PC this edge (select and targets ignored)
//   selWire      in   next-PC source: 0 = pc+PC_INCR, 1/2/3 = jumpTarget1/2/3
//   jumpTarget1  in   jump target for select 1
//   jumpTarget2  in   jump target for select 2
//   jumpTarget3  in   jump target for select 3
//   pc           out  current PC, driven straight from the PC register
// -----------------------------------------------------------------------------
module simple_branch #(
    parameter int                    ADDR_SIZE  = 32,
    parameter int                    BRANCH_OPT = 4,
    parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0,
    parameter int                    PC_INCR    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pcStall,
    input  logic [$clog2(BRANCH_OPT)-1:0]   selWire,
    input  logic [ADDR_SIZE-1:0]            jumpTarget1,
    input  logic [ADDR_SIZE-1:0]            jumpTarget2,
    input  logic [ADDR_SIZE-1:0]            jumpTarget3,
    output logic [ADDR_SIZE-1:0]            pc
);

    logic [ADDR_SIZE-1:0] r_pc;
    logic [ADDR_SIZE-1:0] w_pc_seq;
    logic [ADDR_SIZE-1:0] w_pc_next;

    // Increment truncates to ADDR_SIZE bits, so the top of the address space
    // wraps to zero with no carry out.
    assign w_pc_seq = r_pc + ADDR_SIZE'(PC_INCR);

    // Sequential fetch is the default arm so an unknown select in simulation
    // falls back to pc+PC_INCR. Targets pass through untouched.
    always_comb begin
        w_pc_next = w_pc_seq;
        case (selWire)
            2'd1:    w_pc_next = jumpTarget1;
            2'd2:    w_pc_next = jumpTarget2;
            2'd3:    w_pc_next = jumpTarget3;
            default: w_pc_next = w_pc_seq;
        endcase
    end

    // Reset wins over stall; a stalled edge drops the selection entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!pcStall) begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_simple_branch.sv
module tb_simple_branch;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          pcStall;
    logic [1:0]    selWire;
    logic [AW-1:0] jumpTarget1;
    logic [AW-1:0] jumpTarget2;
    logic [AW-1:0] jumpTarget3;
    logic [AW-1:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simple_branch #(
        .ADDR_SIZE  (AW),
        .BRANCH_OPT (4),
        .RESET_PC   (32'h0),
        .PC_INCR    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcStall     (pcStall),
        .selWire     (selWire),
        .jumpTarget1 (jumpTarget1),
        .jumpTarget2 (jumpTarget2),
        .jumpTarget3 (jumpTarget3),
        .pc          (pc)
    );

    typedef struct {
        logic          rst;
        logic          stall;
        logic [1:0]    sel;
        logic [AW-1:0] t1;
        logic [AW-1:0] t2;
        logic [AW-1:0] t3;
        logic [AW-1:0] exp_pc;
        string         name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic [1:0] sel,
                       input logic [AW-1:0] t1, input logic [AW-1:0] t2,
                       input logic [AW-1:0] t3, input logic [AW-1:0] e,
                       input string nm);
        vec_t v;
        v.rst = r; v.stall = s; v.sel = sel;
        v.t1 = t1; v.t2 = t2; v.t3 = t3;
        v.exp_pc = e; v.name = nm;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, let one rising edge happen, sample 1ns later.
    task automatic step(input logic r, input logic s, input logic [1:0] sel,
                        input logic [AW-1:0] t1, input logic [AW-1:0] t2,
                        input logic [AW-1:0] t3);
        @(negedge clk);
        reset = r; pcStall = s; selWire = sel;
        jumpTarget1 = t1; jumpTarget2 = t2; jumpTarget3 = t3;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [AW-1:0] exp_v);
        n_checks++;
        if (pc !== exp_v) begin
            n_fail++;
            $display("FAIL %s: pc=%h expected=%h", nm, pc, exp_v);
        end else begin
            $display("ok   %s: pc=%h", nm, pc);
        end
    endtask

    initial begin
        logic [AW-1:0] model_pc;
        logic          r, s;
        logic [1:0]    sel;
        logic [AW-1:0] t1, t2, t3;

        reset = 1'b0; pcStall = 1'b0; selWire = 2'd0;
        jumpTarget1 = '0; jumpTarget2 = '0; jumpTarget3 = '0;

        // Reset then sequential
        add(1, 0, 0, 0, 0, 0, 32'h0,        "reset");
        add(0, 0, 0, 0, 0, 0, 32'h4,        "seq1");
        add(0, 0, 0, 0, 0, 0, 32'h8,        "seq2");
        add(0, 0, 0, 0, 0, 0, 32'hC,        "seq3");
        // Back to 8 so the jumps start from pc=8
        add(1, 0, 0, 0, 0, 0, 32'h0,        "reset2");
        add(0, 0, 0, 0, 0, 0, 32'h4,        "seq4");
        add(0, 0, 0, 0, 0, 0, 32'h8,        "seq8");
        add(0, 0, 1, 32'h1000, 32'h9, 32'h9, 32'h1000,     "jump1");
        add(0, 0, 2, 32'h9, 32'h2000, 32'h9, 32'h2000,     "jump2");
        add(0, 0, 3, 32'h9, 32'h9, 32'hDEADBEEC, 32'hDEADBEEC, "jump3");
        // Stall holds across two edges, then released selection takes effect
        add(0, 0, 1, 32'h1000, 0, 0, 32'h1000,        "to1000");
        add(0, 1, 3, 0, 0, 32'h5000, 32'h1000,        "stall_a");
        add(0, 1, 3, 0, 0, 32'h5000, 32'h1000,        "stall_b");
        add(0, 0, 3, 0, 0, 32'h5000, 32'h5000,        "unstall");
        // Stalled sequential select must not advance either
        add(0, 1, 0, 0, 0, 0, 32'h5000,               "stall_seq");
        // Wrap-around
        add(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, "to_top");
        add(0, 0, 0, 0, 0, 0, 32'h0,                   "wrap");
        add(0, 0, 0, 0, 0, 0, 32'h4,                   "after_wrap");
        // Unaligned target passes through unmodified
        add(0, 0, 2, 0, 32'h00001003, 0, 32'h00001003, "unaligned");
        add(0, 0, 0, 0, 0, 0, 32'h00001007,            "seq_unal");
        // Reset over stall
        add(0, 0, 2, 0, 32'h2000, 0, 32'h2000,         "to2000");
        add(1, 1, 3, 0, 0, 32'h7777, 32'h0,            "rst_stall");
        add(0, 0, 0, 0, 0, 0, 32'h4,                   "post_rst");
        // Reset discards a pending jump
        add(0, 0, 3, 0, 0, 32'h3000, 32'h3000,         "to3000");
        add(1, 0, 1, 32'hABC0, 0, 0, 32'h0,            "rst_jump");
        add(0, 0, 1, 32'hABC0, 0, 0, 32'hABC0,         "jump_after");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].sel,
                 vecs[i].t1, vecs[i].t2, vecs[i].t3);
            check(vecs[i].name, vecs[i].exp_pc);
        end

        // Random soak against a reference model
        model_pc = 32'hABC0;
        for (int k = 0; k < 40; k++) begin
            r   = ($urandom_range(0, 15) == 0);
            s   = ($urandom_range(0, 3) == 0);
            sel = 2'($urandom_range(0, 3));
            t1  = $urandom; t2 = $urandom; t3 = $urandom;
            if (k == 20) begin
                t1 = 32'hFFFFFFFC; sel = 2'd1; s = 1'b0; r = 1'b0;
            end
            step(r, s, sel, t1, t2, t3);
            if (r)
                model_pc = 32'h0;
            else if (!s) begin
                case (sel)
                    2'd0: model_pc = model_pc + 32'd4;
                    2'd1: model_pc = t1;
                    2'd2: model_pc = t2;
                    default: model_pc = t3;
                endcase
            end
            check($sformatf("soak%0d r=%0d s=%0d sel=%0d", k, r, s, sel), model_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_branch.md
SIMPLE_BRANCH -- requirements
Module: simple_branch

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 32, giving the width of the PC and jump targets in bits.
REQ-002 The block SHALL have parameter BRANCH_OPT, default 4, giving the number of next-PC sources; only the value 4 is supported.
REQ-003 The block SHALL have parameter RESET_PC, default 0 (ADDR_SIZE bits), giving the PC value loaded on reset.
REQ-004 The block SHALL have parameter PC_INCR, default 4, giving the sequential PC increment.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port reset: input, 1 bit, synchronous active-high reset.
REQ-007 Port pcStall: input, 1 bit; when 1, the PC holds its value.
REQ-008 Port selWire: input, 2 bits, next-PC source select.
REQ-009 Port jumpTarget1: input, ADDR_SIZE bits, branch/jump target for select 1.
REQ-010 Port jumpTarget2: input, ADDR_SIZE bits, branch/jump target for select 2.
REQ-011 Port jumpTarget3: input, ADDR_SIZE bits, branch/jump target for select 3.
REQ-012 Port pc: output, ADDR_SIZE bits, current program counter, driven directly from a register.

Function
REQ-013 The block SHALL hold one ADDR_SIZE-bit PC register; pc SHALL equal this register at all times, with no combinational path from any input to pc.
REQ-014 The block SHALL compute next-PC combinationally as follows:
- selWire=0 -> pc + PC_INCR
- selWire=1 -> jumpTarget1
- selWire=2 -> jumpTarget2
- selWire=3 -> jumpTarget3
REQ-015 On each rising clk edge with reset=0 and pcStall=0, the PC register SHALL load next-PC, so a new value is visible one cycle after the select and targets are presented.
REQ-016 On each rising clk edge with reset=0 and pcStall=1, the PC register SHALL keep its value; selWire and the targets SHALL be ignored that cycle.
REQ-017 Sequential increment SHALL wrap modulo 2^ADDR_SIZE; for example, 32'hFFFFFFFC + 4 -> 32'h00000000, with no overflow flag.
REQ-018 Jump targets SHALL be loaded unmodified, with no alignment masking or range checks.
REQ-019 If selWire is X/Z in simulation, the mux SHALL default to pc + PC_INCR.
REQ-020 Stall SHALL not be sticky: pcStall affects only the edge at which it is sampled high, and no selection is remembered across a stall.

Reset
REQ-021 On a rising clk edge with reset=1, the PC register SHALL load RESET_PC, regardless of pcStall, selWire or the targets.
REQ-022 Reset SHALL take priority over stall.
REQ-023 Reset asserted mid-sequence SHALL discard the pending next-PC.
REQ-024 Before the first reset edge, the pc value SHALL be undefined.
REQ-025 The first edge with reset=0 SHALL apply the normal REQ-015/REQ-016 rules.

Verification
REQ-026 Reset then sequential: reset=1 for one edge, then reset=0, pcStall=0, selWire=0 for 3 edges -> pc = 0, then 4, 8, 12.
REQ-027 Jump select: from pc=8, set selWire=1, jumpTarget1=32'h00001000 -> pc=32'h1000 after one edge; then selWire=2, jumpTarget2=32'h2000 -> 32'h2000; then selWire=3, jumpTarget3=32'hDEADBEEC -> 32'hDEADBEEC.
REQ-028 Stall: with pc=32'h1000, set pcStall=1 and selWire=3, jumpTarget3=32'h5000 for 2 edges -> pc stays 32'h1000; release pcStall -> pc=32'h5000 on the next edge.
REQ-029 Wrap-around: with pc=32'hFFFFFFFC, selWire=0, pcStall=0 -> pc=32'h00000000 after one edge.
REQ-030 Reset over stall: with pc=32'h2000, assert reset=1 and pcStall=1 together for one edge -> pc=0; release reset with selWire=0 -> pc=4 on the next edge.
REQ-031 Random soak: 16+ cycles of random selWire, pcStall and targets -> pc on every edge matches a reference model of REQ-014 to REQ-021.
